// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller.
// - run_state_e: the encoding driven on runState. The board display and the
//   control unit both decode these values.
// - OP_*: opcodes that the control unit decodes into isHalt/isIn/isOut.
//   They are kept here so that both sides use the same values.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RS_RUN       = 2'b00,
        RS_STEP_WAIT = 2'b01,
        RS_IN_WAIT   = 2'b10,
        RS_HALTED    = 2'b11
    } run_state_e;

    localparam logic [5:0] OP_HALT = 6'b010111;
    localparam logic [5:0] OP_OUT  = 6'b010110;
    localparam logic [5:0] OP_IN   = 6'b010101;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Bus between the run controller and its surroundings.
// The control-unit decodes (isHalt/isIn/isOut) and the raw board inputs
// (btnConfirm/btnStep/stepMode) enter the controller. The commit strobes
// and status values leave it.
//   master : the run controller (drives cpuEnable, inLatch, outValid,
//            runState, instrCount)
//   slave  : the datapath/board side (drives decodes, buttons, switch)
import cpu_ctrl_pkg::*;

interface cpu_run_controller_if #(parameter int CNT_W = 32);
    logic             isHalt;
    logic             isIn;
    logic             isOut;
    logic             btnConfirm;
    logic             btnStep;
    logic             stepMode;
    logic             cpuEnable;
    logic             inLatch;
    logic             outValid;
    run_state_e       runState;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  isHalt, isIn, isOut, btnConfirm, btnStep, stepMode,
        output cpuEnable, inLatch, outValid, runState, instrCount
    );

    modport slave (
        output isHalt, isIn, isOut, btnConfirm, btnStep, stepMode,
        input  cpuEnable, inLatch, outValid, runState, instrCount
    );
endinterface

// File: rtl/button_conditioner.sv
// Conditions one raw board button into a single-cycle press pulse.
// Stages: 2-flop synchronizer, then a debouncer, then a registered rise
// detector.
// The debouncer accepts a new level only after the synchronized input has
// differed from the accepted level for DEBOUNCE_CYCLES consecutive cycles.
// Any return to the accepted level restarts the count.
// Latency: a raw rise first sampled at edge N produces a pulse in cycle
// N+2+DEBOUNCE_CYCLES.
// Ports:
//   clock   : system clock
//   rst     : asynchronous active-high reset, clears all state
//   btn_raw : asynchronous, active-high button
//   pulse   : one-cycle pulse on an accepted 0->1 transition
import cpu_ctrl_pkg::*;

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_dly_q, level_dly_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        // The counter runs only while the input disagrees with the accepted
        // level, so a single agreeing sample clears it.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                level_d = sync2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
        level_dly_d = level_q;
        pulse_d     = level_q & ~level_dly_q;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            pulse_q     <= pulse_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/cpu_run_controller.sv
// Execution sequencer for the single-cycle CPU. It decides in which cycles
// the datapath commits the current instruction (cpuEnable).
// Operating modes: free-run, single-step on the step button, and blocking
// IN (waits for the confirm button). It stops permanently on HALT.
// Ports:
//   clock    : system clock
//   resetCPU : asynchronous active-high reset
//   bus      : master side of cpu_run_controller_if. Carries the decodes,
//              the raw buttons and switch, the commit strobes, runState and
//              the saturating committed-instruction count.
import cpu_ctrl_pkg::*;

module cpu_run_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 32
) (
    input  logic                 clock,
    input  logic                 resetCPU,
    cpu_run_controller_if.master bus
);
    logic             confirm_pulse, step_pulse;
    logic [1:0]       step_sync_q, step_sync_d;
    logic             step_s;
    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             commit, in_latch;
    logic             cpu_en, latch_en;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
        .clock   (clock),
        .rst     (resetCPU),
        .btn_raw (bus.btnConfirm),
        .pulse   (confirm_pulse)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clock   (clock),
        .rst     (resetCPU),
        .btn_raw (bus.btnStep),
        .pulse   (step_pulse)
    );

    // The mode switch is a slow level, so it is synchronized but not debounced.
    assign step_sync_d = {step_sync_q[0], bus.stepMode};
    assign step_s      = step_sync_q[1];

    // Decode priority is isHalt > isIn > commit. Pulses that the current state
    // does not consume are simply ignored.
    always_comb begin
        state_d  = state_q;
        commit   = 1'b0;
        in_latch = 1'b0;
        case (state_q)
            RS_RUN: begin
                if (bus.isHalt)
                    state_d = RS_HALTED;
                else if (bus.isIn)
                    state_d = RS_IN_WAIT;
                else begin
                    commit  = 1'b1;
                    state_d = step_s ? RS_STEP_WAIT : RS_RUN;
                end
            end
            RS_STEP_WAIT: begin
                if (step_pulse) begin
                    if (bus.isHalt)
                        state_d = RS_HALTED;
                    else if (bus.isIn)
                        state_d = RS_IN_WAIT;
                    else
                        commit = 1'b1;
                end else if (!step_s) begin
                    state_d = RS_RUN;
                end
            end
            RS_IN_WAIT: begin
                if (confirm_pulse) begin
                    commit   = 1'b1;
                    in_latch = 1'b1;
                    state_d  = step_s ? RS_STEP_WAIT : RS_RUN;
                end
            end
            default: ; // HALTED absorbs everything until reset
        endcase
    end

    // While reset is held, state_q reads RUN, which would otherwise commit.
    // The strobes are therefore forced low by reset itself.
    assign cpu_en   = commit & ~resetCPU;
    assign latch_en = in_latch & ~resetCPU;

    assign count_d = (cpu_en && (count_q != '1)) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clock or posedge resetCPU) begin
        if (resetCPU) begin
            state_q     <= RS_RUN;
            count_q     <= '0;
            step_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            step_sync_q <= step_sync_d;
        end
    end

    assign bus.cpuEnable  = cpu_en;
    assign bus.inLatch    = latch_en;
    assign bus.outValid   = cpu_en & bus.isOut;
    assign bus.runState   = state_q;
    assign bus.instrCount = count_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
import cpu_ctrl_pkg::*;

module tb_cpu_run_controller;
    logic clock;
    logic resetCPU;
    int   total = 0;
    int   bad   = 0;
    int   exp_cnt = 0;

    cpu_run_controller_if #(.CNT_W(32)) bus ();

    cpu_run_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(32)) dut (
        .clock    (clock),
        .resetCPU (resetCPU),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       is_halt;
        logic       is_in;
        logic       is_out;
        logic       exp_en;
        logic       exp_outv;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tbl[11];
    logic bnc[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs are already set (posedge+1). Check this cycle's outputs at the
    // negedge, advance the model count, then move to the next posedge+1.
    task automatic cyc(input string nm, input logic en, input logic latch,
                       input logic outv, input logic [1:0] st);
        @(negedge clock);
        chk({nm, ".cpuEnable"}, {31'd0, bus.cpuEnable}, {31'd0, en});
        chk({nm, ".inLatch"}, {31'd0, bus.inLatch}, {31'd0, latch});
        chk({nm, ".outValid"}, {31'd0, bus.outValid}, {31'd0, outv});
        chk({nm, ".runState"}, {30'd0, bus.runState}, {30'd0, st});
        chk({nm, ".instrCount"}, bus.instrCount, exp_cnt);
        if (en) exp_cnt++;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.isHalt = 0; bus.isIn = 0; bus.isOut = 0;
        bus.btnConfirm = 0; bus.btnStep = 0; bus.stepMode = 0;
    endtask

    task automatic do_reset(input string nm);
        resetCPU = 1'b1;
        clear_inputs();
        #1;
        chk({nm, ".rst.cpuEnable"}, {31'd0, bus.cpuEnable}, 32'd0);
        chk({nm, ".rst.inLatch"}, {31'd0, bus.inLatch}, 32'd0);
        chk({nm, ".rst.runState"}, {30'd0, bus.runState}, 32'd0);
        chk({nm, ".rst.instrCount"}, bus.instrCount, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        resetCPU = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        // Ten plain commits, then one OUT commit.
        for (int i = 0; i < 10; i++) tbl[i] = '{0, 0, 0, 1, 0, 2'd0};
        tbl[10] = '{0, 0, 1, 1, 1, 2'd0};
        bnc = '{1, 1, 0, 1, 0, 0, 1};

        // 1: reset, then free run
        do_reset("t1");
        for (int i = 0; i < 11; i++) begin
            bus.isHalt = tbl[i].is_halt;
            bus.isIn   = tbl[i].is_in;
            bus.isOut  = tbl[i].is_out;
            cyc($sformatf("t1.v%0d", i), tbl[i].exp_en, 1'b0, tbl[i].exp_outv, tbl[i].exp_state);
        end
        bus.isOut = 0;

        // 2: IN waits for confirm; pulse lands 7 cycles after the button goes up
        bus.isIn = 1;
        cyc("t2.enter", 0, 0, 0, 2'd0);
        bus.btnConfirm = 1;
        cyc("t2.press", 0, 0, 0, 2'd2);
        for (int i = 0; i < 6; i++) cyc($sformatf("t2.wait%0d", i), 0, 0, 0, 2'd2);
        cyc("t2.commit", 1, 1, 0, 2'd2);
        bus.isIn = 0;
        bus.btnConfirm = 0;
        for (int i = 0; i < 8; i++) cyc($sformatf("t2.run%0d", i), 1, 0, 0, 2'd0);

        // 3: step mode, clean press then bouncy press
        bus.stepMode = 1;
        for (int i = 0; i < 3; i++) cyc($sformatf("t3.sync%0d", i), 1, 0, 0, 2'd0);
        bus.btnStep = 1;
        for (int i = 0; i < 7; i++) cyc($sformatf("t3.p1w%0d", i), 0, 0, 0, 2'd1);
        cyc("t3.p1", 1, 0, 0, 2'd1);
        bus.btnStep = 0;
        for (int i = 0; i < 10; i++) cyc($sformatf("t3.rel%0d", i), 0, 0, 0, 2'd1);
        for (int i = 0; i < 7; i++) begin
            bus.btnStep = bnc[i];
            cyc($sformatf("t3.bnc%0d", i), 0, 0, 0, 2'd1);
        end
        for (int i = 0; i < 6; i++) cyc($sformatf("t3.p2w%0d", i), 0, 0, 0, 2'd1);
        cyc("t3.p2", 1, 0, 0, 2'd1);
        bus.btnStep = 0;
        bus.stepMode = 0;
        for (int i = 0; i < 3; i++) cyc($sformatf("t3.leave%0d", i), 0, 0, 0, 2'd1);
        cyc("t3.run", 1, 0, 0, 2'd0);

        // 4: OUT then HALT; buttons do nothing afterwards
        bus.isOut = 1;
        cyc("t4.out", 1, 0, 1, 2'd0);
        bus.isOut = 0;
        bus.isHalt = 1;
        cyc("t4.halt", 0, 0, 0, 2'd0);
        bus.btnStep = 1;
        bus.btnConfirm = 1;
        for (int i = 0; i < 12; i++) cyc($sformatf("t4.hold%0d", i), 0, 0, 0, 2'd3);
        bus.btnStep = 0;
        bus.btnConfirm = 0;
        for (int i = 0; i < 8; i++) cyc($sformatf("t4.rel%0d", i), 0, 0, 0, 2'd3);

        // 5: HALT beats IN
        do_reset("t5");
        bus.isHalt = 1;
        bus.isIn = 1;
        cyc("t5.both", 0, 0, 0, 2'd0);
        for (int i = 0; i < 3; i++) cyc($sformatf("t5.halted%0d", i), 0, 0, 0, 2'd3);

        // 6: reset mid-IN_WAIT and mid-debounce, off the clock edge
        do_reset("t6a");
        bus.isIn = 1;
        cyc("t6.enter", 0, 0, 0, 2'd0);
        bus.btnConfirm = 1;
        for (int i = 0; i < 3; i++) cyc($sformatf("t6.deb%0d", i), 0, 0, 0, 2'd2);
        #2;
        resetCPU = 1'b1;
        bus.btnConfirm = 0;
        #1;
        chk("t6.async.runState", {30'd0, bus.runState}, 32'd0);
        chk("t6.async.cpuEnable", {31'd0, bus.cpuEnable}, 32'd0);
        chk("t6.async.inLatch", {31'd0, bus.inLatch}, 32'd0);
        chk("t6.async.instrCount", bus.instrCount, 32'd0);
        exp_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        resetCPU = 1'b0;
        cyc("t6.after", 0, 0, 0, 2'd0);
        for (int i = 0; i < 10; i++) cyc($sformatf("t6.nostale%0d", i), 0, 0, 0, 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
